mem_burst_adapter: RTL and testbench
====================================

# mem_burst_adapter

Parametrised line-to-burst memory adapter between one or more line-granular requesters (L2 cache banks, DMA) and the 64-bit burst memory port of the chip. It is the successor of the single-requester cacheline buffer. It generalises line width, bus width and requester count, and adds round-robin arbitration, line-address alignment and `raddr`-tagged read-beat filtering. One transaction is in flight at a time.

## Interface
- `NUM_PORTS`, 2: number of requester ports, ≥1.
- `LINE_BITS`, 256: cacheline width.
- `BUS_BITS`, 64: memory beat width. `BEATS = LINE_BITS/BUS_BITS` is a power of two, ≥2.
- `ADDR_BITS`, 32: address width.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (0 = reset).
- `port_addr` in `[NUM_PORTS][ADDR_BITS]`: line address per port.
- `port_read` in `[NUM_PORTS]`: line read request, held until `port_resp`.
- `port_write` in `[NUM_PORTS]`: line write request, held until `port_resp`.
- `port_wdata` in `[NUM_PORTS][LINE_BITS]`: write line, held with `port_write`.
- `port_rdata` out `LINE_BITS`: shared read line, valid while any `port_resp` is high.
- `port_resp` out `[NUM_PORTS]`: one-hot completion pulse.
- `bmem_addr` out `ADDR_BITS`: line-aligned burst address.
- `bmem_read` out 1: read burst request.
- `bmem_write` out 1: write beat valid.
- `bmem_wdata` out `BUS_BITS`: write beat.
- `bmem_ready` in 1: memory accepts request/beat this cycle.
- `bmem_raddr` in `ADDR_BITS`: tag of the returning read beat.
- `bmem_rdata` in `BUS_BITS`: read beat.
- `bmem_rvalid` in 1: read beat valid.

## Operation
- **FSM states:** IDLE, RD_REQ, RD_DATA, WR, RESP.
- **IDLE:**
  - Choose a requesting port (`port_read|port_write`) round-robin, starting at `last_gnt+1` mod `NUM_PORTS`.
  - Latch the grant index g, the address with the low `log2(LINE_BITS/8)` bits cleared, the op, and `port_wdata[g]`.
  - Clear `beat_cnt`. Go to WR if `port_write[g]`, else RD_REQ.
  - If a port asserts both read and write (illegal), write wins.
- **RD_REQ:** `bmem_read=1`, `bmem_addr`=latched address. When `bmem_ready=1` at the edge, go to RD_DATA.
- **RD_DATA:**
  - Each cycle with `bmem_rvalid=1` and `bmem_raddr==latched address`: write `bmem_rdata` into line slice `beat_cnt` (beat 0 = bits `[BUS_BITS-1:0]`), then increment `beat_cnt`.
  - Beats with a mismatched `raddr` are dropped.
  - When beat `BEATS-1` is stored, go to RESP.
- **WR:**
  - `bmem_write=1`, `bmem_addr`=latched address, `bmem_wdata`=slice `beat_cnt` of the latched line.
  - `beat_cnt` advances only on cycles with `bmem_ready=1`. `bmem_write` stays high across ready-low stalls.
  - When the last beat is accepted, go to RESP.
- **RESP:**
  - `port_resp[g]=1` for exactly one cycle. `port_rdata` = line buffer (don't-care on writes).
  - Set `last_gnt=g`, return to IDLE.
  - The next grant is evaluated in the IDLE cycle after RESP.
- **Outputs:** all bmem outputs are Moore decodes of state/registers. `bmem_read`/`bmem_write` are 0 outside RD_REQ/WR.
- `beat_cnt` is `log2(BEATS)` bits and wraps to 0 after the last beat.

## Timing
- **Reset:** `rst=0` at an edge forces IDLE, `beat_cnt=0`, `last_gnt=NUM_PORTS-1` (port 0 first), and all outputs 0: `bmem_read`, `bmem_write`, `bmem_addr`, `bmem_wdata`, `port_resp`, `port_rdata`.
  - Reset mid-transaction aborts it with no `port_resp`.
  - Read beats arriving after reset are ignored.
- **Read latency, zero memory stalls:**
  - Request seen in IDLE at cycle 0.
  - `bmem_read` high in cycle 1.
  - First beat usable from cycle 2.
  - `port_resp` in the cycle after the last beat is stored.
- **Write latency, `bmem_ready` always 1:**
  - `bmem_write` high in cycles 1..`BEATS`.
  - `port_resp` in cycle `BEATS+1`.
- **Requester rules:**
  - A requester must drop read/write in the cycle after it sees `port_resp`.
  - Requests are not sampled in RD_REQ/RD_DATA/WR/RESP.
- **Simultaneous requests:** resolved strictly round-robin. No port waits more than `NUM_PORTS-1` transactions.

## Test plan
- **Single read, `BEATS=4`:** port0 reads `0x0000_1234`.
  - Required: `bmem_addr=0x0000_1220` and `bmem_read` for one cycle with ready=1.
  - Return beats A,B,C,D tagged `0x1220`.
  - Required: `port_rdata={D,C,B,A}` and a single-cycle `port_resp[0]`.
- **Write with stalls:** port1 writes line `{W3,W2,W1,W0}`, `bmem_ready` low on the 2nd cycle of the burst.
  - Required: beats W0,W1,W1,W2,W3 with `bmem_write` high 5 cycles.
  - Required: memory captures W0..W3 once each, then `port_resp[1]`.
- **Tag filter:** during RD_DATA inject an rvalid beat tagged `0x4000`.
  - Required: it is dropped and `beat_cnt` is unchanged.
- **Arbitration:** ports 0 and 1 request continuously after reset.
  - Required grant order 0,1,0,1.
  - Required: both read and write on one port → write served.
- **Reset mid-burst:** `rst=0` after 2 of 4 read beats.
  - Required: no `port_resp`, outputs 0 next cycle.
  - Remaining beats ignored; a new read completes normally.
- **Parametrisation:** `LINE_BITS=512`, `BUS_BITS=64`, `NUM_PORTS=4` (8 beats).
  - Required: correct line assembly, and all 4 ports are served within 4 transactions.

Source files
------------

// File: rtl/mem_burst_adapter.sv
// Line-to-burst memory adapter: round-robin arbitrates line-granular requesters
// and moves one cacheline per transaction over a narrower burst memory port.
module mem_burst_adapter #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_BITS = 256,
  parameter int BUS_BITS  = 64,
  parameter int ADDR_BITS = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]                port_read,
  input  logic [NUM_PORTS-1:0]                port_write,
  input  logic [NUM_PORTS-1:0][LINE_BITS-1:0] port_wdata,
  output logic [LINE_BITS-1:0]                port_rdata,
  output logic [NUM_PORTS-1:0]                port_resp,
  output logic [ADDR_BITS-1:0]                bmem_addr,
  output logic                                bmem_read,
  output logic                                bmem_write,
  output logic [BUS_BITS-1:0]                 bmem_wdata,
  input  logic                                bmem_ready,
  input  logic [ADDR_BITS-1:0]                bmem_raddr,
  input  logic [BUS_BITS-1:0]                 bmem_rdata,
  input  logic                                bmem_rvalid
);

  localparam int BEATS = LINE_BITS / BUS_BITS;
  localparam int BW    = $clog2(BEATS);
  localparam int GW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OFF   = $clog2(LINE_BITS / 8);

  localparam logic [ADDR_BITS-1:0] ADDR_MASK = {{(ADDR_BITS-OFF){1'b1}}, {OFF{1'b0}}};
  localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0]        LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_e;

  state_e                             state_q, state_d;
  logic [GW-1:0]                      gnt_q, gnt_d;
  logic [GW-1:0]                      last_gnt_q, last_gnt_d;
  logic [ADDR_BITS-1:0]               addr_q, addr_d;
  logic [BW-1:0]                      beat_cnt_q, beat_cnt_d;
  logic [BEATS-1:0][BUS_BITS-1:0]     line_q, line_d;

  logic          req_found;
  logic [GW-1:0] req_idx;
  logic [GW-1:0] cand_idx;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_idx = GW'((int'(last_gnt_q) + i) % NUM_PORTS);
      if (!req_found && (port_read[cand_idx] || port_write[cand_idx])) begin
        req_found = 1'b1;
        req_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          gnt_d      = req_idx;
          addr_d     = port_addr[req_idx] & ADDR_MASK;
          line_d     = port_wdata[req_idx];
          beat_cnt_d = '0;
          state_d    = port_write[req_idx] ? S_WR : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (bmem_ready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        // Beats tagged for another line are dropped without advancing.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          line_d[beat_cnt_q] = bmem_rdata;
          beat_cnt_d         = beat_cnt_q + BW'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = S_RESP;
        end
      end
      S_WR: begin
        if (bmem_ready) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_gnt_d = gnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= LAST_PORT;
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // NOTE: the line buffer is datapath storage and is not reset; every output
  // that exposes it is gated by state, so stale contents never escape.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign bmem_read  = (state_q == S_RD_REQ);
  assign bmem_write = (state_q == S_WR);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? line_q[beat_cnt_q] : '0;
  assign port_rdata = (state_q == S_RESP) ? line_q : '0;

  always_comb begin
    port_resp = '0;
    if (state_q == S_RESP) port_resp[gnt_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_burst_adapter.sv
// Scoreboard bench for mem_burst_adapter: a 2-port/256-bit instance and a
// 4-port/512-bit instance, each driven by a small behavioural burst memory.
module tb_mem_burst_adapter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2 ports, 256-bit lines, 4 beats
  logic [1:0][31:0]  a_port_addr;
  logic [1:0]        a_port_read, a_port_write;
  logic [1:0][255:0] a_port_wdata;
  logic [255:0]      a_port_rdata;
  logic [1:0]        a_port_resp;
  logic [31:0]       a_bmem_addr, a_bmem_raddr;
  logic              a_bmem_read, a_bmem_write, a_bmem_ready, a_bmem_rvalid;
  logic [63:0]       a_bmem_wdata, a_bmem_rdata;

  // 4 ports, 512-bit lines, 8 beats
  logic [3:0][31:0]  b_port_addr;
  logic [3:0]        b_port_read, b_port_write;
  logic [3:0][511:0] b_port_wdata;
  logic [511:0]      b_port_rdata;
  logic [3:0]        b_port_resp;
  logic [31:0]       b_bmem_addr, b_bmem_raddr;
  logic              b_bmem_read, b_bmem_write, b_bmem_ready, b_bmem_rvalid;
  logic [63:0]       b_bmem_wdata, b_bmem_rdata;

  mem_burst_adapter dut (
    .clk(clk), .rst(rst),
    .port_addr(a_port_addr), .port_read(a_port_read), .port_write(a_port_write),
    .port_wdata(a_port_wdata), .port_rdata(a_port_rdata), .port_resp(a_port_resp),
    .bmem_addr(a_bmem_addr), .bmem_read(a_bmem_read), .bmem_write(a_bmem_write),
    .bmem_wdata(a_bmem_wdata), .bmem_ready(a_bmem_ready), .bmem_raddr(a_bmem_raddr),
    .bmem_rdata(a_bmem_rdata), .bmem_rvalid(a_bmem_rvalid)
  );

  mem_burst_adapter #(.NUM_PORTS(4), .LINE_BITS(512), .BUS_BITS(64), .ADDR_BITS(32)) dut_b (
    .clk(clk), .rst(rst),
    .port_addr(b_port_addr), .port_read(b_port_read), .port_write(b_port_write),
    .port_wdata(b_port_wdata), .port_rdata(b_port_rdata), .port_resp(b_port_resp),
    .bmem_addr(b_bmem_addr), .bmem_read(b_bmem_read), .bmem_write(b_bmem_write),
    .bmem_wdata(b_bmem_wdata), .bmem_ready(b_bmem_ready), .bmem_raddr(b_bmem_raddr),
    .bmem_rdata(b_bmem_rdata), .bmem_rvalid(b_bmem_rvalid)
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [511:0] line;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] wseen_q[$];
  logic [63:0] wcap_q[$];
  int          rd_cycles;
  logic [31:0] mem_addr_seen;
  logic [1:0]  a_resp_vec;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [63:0] beat_of(input logic [31:0] a, input int k);
    return {a ^ 32'h5A5A_0000, 32'h0B00_0000 + 32'(k)};
  endfunction

  function automatic logic [511:0] line_of(input logic [31:0] a, input int beats);
    logic [511:0] l = '0;
    for (int k = 0; k < beats; k++) l[k*64 +: 64] = beat_of(a, k);
    return l;
  endfunction

  task automatic idle_inputs();
    a_port_addr = '0; a_port_read = '0; a_port_write = '0; a_port_wdata = '0;
    a_bmem_ready = 1'b1; a_bmem_raddr = '0; a_bmem_rdata = '0; a_bmem_rvalid = 1'b0;
    b_port_addr = '0; b_port_read = '0; b_port_write = '0; b_port_wdata = '0;
    b_bmem_ready = 1'b1; b_bmem_raddr = '0; b_bmem_rdata = '0; b_bmem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Behavioural memory for the 2-port instance. Returns at the negedge where
  // port_resp is seen, or where stop_after read beats have been delivered.
  task automatic mem_a(input int stall_at, input bit bad_tag, input int stop_after,
                       output int rport, output logic [255:0] rline, output int rcyc);
    int beat, wcyc;
    bit rd_phase, injected;
    logic [31:0] tag;
    rport = -1; rline = '0; rcyc = -1; beat = 0; wcyc = 0;
    rd_phase = 1'b0; injected = 1'b0; tag = '0; a_resp_vec = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      a_bmem_rvalid = 1'b0;
      a_bmem_ready  = 1'b1;
      if (a_port_resp != '0) begin
        for (int p = 0; p < 2; p++) if (a_port_resp[p]) rport = p;
        a_resp_vec = a_port_resp;
        rline = a_port_rdata;
        rcyc  = cyc;
        break;
      end
      if (a_bmem_write) begin
        mem_addr_seen = a_bmem_addr;
        a_bmem_ready  = (wcyc != stall_at);
        wseen_q.push_back(a_bmem_wdata);
        if (a_bmem_ready) wcap_q.push_back(a_bmem_wdata);
        wcyc++;
      end else if (a_bmem_read) begin
        mem_addr_seen = a_bmem_addr;
        tag = a_bmem_addr;
        rd_phase = 1'b1;
        rd_cycles++;
      end else if (rd_phase && beat < 4) begin
        if (beat == stop_after) break;
        a_bmem_rvalid = 1'b1;
        if (bad_tag && beat == 1 && !injected) begin
          a_bmem_raddr = 32'h0000_4000;
          a_bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          injected = 1'b1;
        end else begin
          a_bmem_raddr = tag;
          a_bmem_rdata = beat_of(tag, beat);
          beat++;
        end
      end
    end
  endtask

  // Pops the scoreboard and compares one completed 2-port transaction.
  task automatic check_a(input string name, input int rport, input logic [255:0] rline,
                         input bit is_read);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s no_expectation: got resp port %0d, required none", name, rport);
      return;
    end
    e = sb_q.pop_front();
    if (a_resp_vec !== (2'b01 << e.port) || rport != e.port) begin
      n_fail++;
      $display("FAIL %s resp: got %b, required one-hot port %0d", name, a_resp_vec, e.port);
    end
    n_assert++;
    if (mem_addr_seen !== e.addr) begin
      n_fail++;
      $display("FAIL %s bmem_addr: got %h, required %h", name, mem_addr_seen, e.addr);
    end
    if (is_read) begin
      n_assert++;
      if (rline !== e.line[255:0]) begin
        n_fail++;
        $display("FAIL %s rdata: got %h, required %h", name, rline, e.line[255:0]);
      end
    end
  endtask

  task automatic check_pulse_a(input string name);
    @(negedge clk);
    n_assert++;
    if (a_port_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL %s resp_width: got %b one cycle later, required 00", name, a_port_resp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_assert++;
    if ({a_bmem_read, a_bmem_write, a_bmem_addr, a_bmem_wdata, a_port_resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_bmem_a: got r=%b w=%b a=%h d=%h resp=%b, required all 0",
               a_bmem_read, a_bmem_write, a_bmem_addr, a_bmem_wdata, a_port_resp);
    end
    n_assert++;
    if (a_port_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata_a: got %h, required 0", a_port_rdata);
    end
    n_assert++;
    if ({b_bmem_read, b_bmem_write, b_bmem_addr, b_port_resp, b_port_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got r=%b w=%b a=%h resp=%b, required all 0",
               b_bmem_read, b_bmem_write, b_bmem_addr, b_port_resp);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    int rport, rcyc;
    logic [255:0] rline;
    a_port_addr[0] = 32'h0000_1234;
    a_port_read[0] = 1'b1;
    sb_q.push_back('{0, 32'h0000_1220, line_of(32'h0000_1220, 4)});
    rd_cycles = 0;
    mem_a(-1, 1'b0, -1, rport, rline, rcyc);
    a_port_read[0] = 1'b0;
    check_a("single_read", rport, rline, 1'b1);
    n_assert++;
    if (rd_cycles != 1) begin
      n_fail++;
      $display("FAIL single_read bmem_read_cycles: got %0d, required 1", rd_cycles);
    end
    n_assert++;
    if (rcyc != 5) begin
      n_fail++;
      $display("FAIL single_read latency: got resp at %0d, required 5", rcyc);
    end
    check_pulse_a("single_read");
  endtask

  task automatic test_write_stall();
    int rport, rcyc;
    logic [255:0] rline, wline;
    logic [319:0] got_seen, want_seen;
    logic [255:0] got_cap;
    for (int k = 0; k < 4; k++) wline[k*64 +: 64] = 64'hC0FF_EE00_0000_0000 + 64'(k * 17 + 3);
    a_port_addr[1]  = 32'h0000_2047;
    a_port_wdata[1] = wline;
    a_port_write[1] = 1'b1;
    sb_q.push_back('{1, 32'h0000_2040, {256'h0, wline}});
    wseen_q.delete(); wcap_q.delete();
    mem_a(1, 1'b0, -1, rport, rline, rcyc);
    a_port_write[1] = 1'b0;
    check_a("write_stall", rport, rline, 1'b0);
    want_seen = {wline[255:192], wline[191:128], wline[127:64], wline[127:64], wline[63:0]};
    got_seen = '0;
    got_cap  = '0;
    if (wseen_q.size() == 5) for (int i = 0; i < 5; i++) got_seen[i*64 +: 64] = wseen_q[i];
    if (wcap_q.size() == 4)  for (int i = 0; i < 4; i++) got_cap[i*64 +: 64]  = wcap_q[i];
    n_assert++;
    if (wseen_q.size() != 5 || got_seen !== want_seen) begin
      n_fail++;
      $display("FAIL write_stall beats_presented: got %0d beats %h, required 5 beats %h",
               wseen_q.size(), got_seen, want_seen);
    end
    n_assert++;
    if (wcap_q.size() != 4 || got_cap !== wline) begin
      n_fail++;
      $display("FAIL write_stall beats_accepted: got %0d beats %h, required 4 beats %h",
               wcap_q.size(), got_cap, wline);
    end
    check_pulse_a("write_stall");
  endtask

  task automatic test_tag_filter();
    int rport, rcyc;
    logic [255:0] rline;
    a_port_addr[0] = 32'h0000_3010;
    a_port_read[0] = 1'b1;
    sb_q.push_back('{0, 32'h0000_3000, line_of(32'h0000_3000, 4)});
    mem_a(-1, 1'b1, -1, rport, rline, rcyc);
    a_port_read[0] = 1'b0;
    check_a("tag_filter", rport, rline, 1'b1);
    n_assert++;
    if (rcyc != 6) begin
      n_fail++;
      $display("FAIL tag_filter latency: got resp at %0d, required 6", rcyc);
    end
  endtask

  task automatic test_arbitration();
    int rport, rcyc;
    logic [255:0] rline, wline;
    logic [255:0] got_cap;
    do_reset();
    a_port_addr[0] = 32'h0000_5008;
    a_port_addr[1] = 32'h0000_6010;
    a_port_read    = 2'b11;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) sb_q.push_back('{0, 32'h0000_5000, line_of(32'h0000_5000, 4)});
      else            sb_q.push_back('{1, 32'h0000_6000, line_of(32'h0000_6000, 4)});
      mem_a(-1, 1'b0, -1, rport, rline, rcyc);
      check_a("arbitration", rport, rline, 1'b1);
    end
    a_port_read = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 4; k++) wline[k*64 +: 64] = 64'h7777_0000_0000_0000 + 64'(k + 1);
    a_port_addr[0]  = 32'h0000_7000;
    a_port_wdata[0] = wline;
    a_port_read[0]  = 1'b1;
    a_port_write[0] = 1'b1;
    sb_q.push_back('{0, 32'h0000_7000, {256'h0, wline}});
    wseen_q.delete(); wcap_q.delete();
    rd_cycles = 0;
    mem_a(-1, 1'b0, -1, rport, rline, rcyc);
    a_port_read[0]  = 1'b0;
    a_port_write[0] = 1'b0;
    check_a("write_wins", rport, rline, 1'b0);
    got_cap = '0;
    if (wcap_q.size() == 4) for (int i = 0; i < 4; i++) got_cap[i*64 +: 64] = wcap_q[i];
    n_assert++;
    if (rd_cycles != 0 || wcap_q.size() != 4 || got_cap !== wline) begin
      n_fail++;
      $display("FAIL write_wins beats: got rd_cycles=%0d %0d beats %h, required 0 and 4 beats %h",
               rd_cycles, wcap_q.size(), got_cap, wline);
    end
    n_assert++;
    if (rcyc != 4) begin
      n_fail++;
      $display("FAIL write_wins latency: got resp at %0d, required 4", rcyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int rport, rcyc;
    logic [255:0] rline;
    @(negedge clk);
    a_port_addr[0] = 32'h0000_8000;
    a_port_read[0] = 1'b1;
    mem_a(-1, 1'b0, 2, rport, rline, rcyc);
    n_assert++;
    if (rport != -1) begin
      n_fail++;
      $display("FAIL reset_mid_burst early_resp: got port %0d, required none", rport);
    end
    rst = 1'b0;
    a_port_read[0] = 1'b0;
    a_bmem_rvalid = 1'b1;
    a_bmem_raddr  = 32'h0000_8000;
    a_bmem_rdata  = beat_of(32'h0000_8000, 2);
    @(negedge clk);
    n_assert++;
    if ({a_port_resp, a_bmem_read, a_bmem_write, a_bmem_addr, a_bmem_wdata, a_port_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst outputs: got resp=%b r=%b w=%b a=%h, required all 0",
               a_port_resp, a_bmem_read, a_bmem_write, a_bmem_addr);
    end
    rst = 1'b1;
    a_bmem_rdata = beat_of(32'h0000_8000, 3);
    @(negedge clk);
    a_bmem_rvalid = 1'b0;
    n_assert++;
    if ({a_port_resp, a_bmem_read} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_burst stale_beats: got resp=%b read=%b, required 000",
               a_port_resp, a_bmem_read);
    end
    a_port_addr[1] = 32'h0000_9001;
    a_port_read[1] = 1'b1;
    sb_q.push_back('{1, 32'h0000_9000, line_of(32'h0000_9000, 4)});
    mem_a(-1, 1'b0, -1, rport, rline, rcyc);
    a_port_read[1] = 1'b0;
    check_a("after_reset_read", rport, rline, 1'b1);
  endtask

  task automatic test_param_b();
    int served[4];
    int nresp, beat, p;
    bit rd_phase, stalled;
    logic [31:0] tag, addr_seen;
    exp_t e;
    served = '{0, 0, 0, 0};
    nresp = 0; beat = 0; p = 0; rd_phase = 1'b0; stalled = 1'b0; tag = '0; addr_seen = '0;
    @(negedge clk);
    for (int q = 0; q < 4; q++) begin
      b_port_addr[q] = 32'h0001_0000 + 32'(q) * 32'h1000 + 32'h13;
      sb_q.push_back('{q, 32'h0001_0000 + 32'(q) * 32'h1000,
                       line_of(32'h0001_0000 + 32'(q) * 32'h1000, 8)});
    end
    b_port_read = 4'b1111;
    for (int cyc = 0; cyc < 200 && nresp < 4; cyc++) begin
      @(negedge clk);
      b_bmem_rvalid = 1'b0;
      b_bmem_ready  = 1'b1;
      if (b_port_resp != '0) begin
        for (int i = 0; i < 4; i++) if (b_port_resp[i]) p = i;
        e = sb_q.pop_front();
        n_assert++;
        if (b_port_resp !== (4'b0001 << e.port) || addr_seen !== e.addr) begin
          n_fail++;
          $display("FAIL param_b grant: got resp=%b addr=%h, required port %0d addr %h",
                   b_port_resp, addr_seen, e.port, e.addr);
        end
        n_assert++;
        if (b_port_rdata !== e.line) begin
          n_fail++;
          $display("FAIL param_b rdata: got %h, required %h", b_port_rdata, e.line);
        end
        served[p]++;
        b_port_read[p] = 1'b0;
        rd_phase = 1'b0;
        stalled  = 1'b0;
        nresp++;
      end else if (b_bmem_read) begin
        addr_seen = b_bmem_addr;
        tag = b_bmem_addr;
        b_bmem_ready = stalled;
        stalled  = 1'b1;
        rd_phase = b_bmem_ready;
        beat = 0;
      end else if (rd_phase && beat < 8) begin
        b_bmem_rvalid = 1'b1;
        b_bmem_raddr  = tag;
        b_bmem_rdata  = beat_of(tag, beat);
        beat++;
      end
    end
    n_assert++;
    if (nresp != 4 || served[0] != 1 || served[1] != 1 || served[2] != 1 || served[3] != 1) begin
      n_fail++;
      $display("FAIL param_b fairness: got %0d resps served=%0d,%0d,%0d,%0d, required 4 resps 1,1,1,1",
               nresp, served[0], served[1], served[2], served[3]);
    end
    b_port_read = '0;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_stall();
    test_tag_filter();
    test_arbitration();
    test_reset_mid_burst();
    test_param_b();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
